food_renderer: RTL and testbench

Sequential sprite blitter that drives the food sprite layout ROM and turns one food tile into a stream of framebuffer pixel writes. It accepts a request of tile coordinates plus food type, scans the 8x8 sprite in row-major order through the layout's (x, y, type) → 2-bit value interface, and emits each pixel with absolute screen coordinates over a valid/ready handshake. It sits between the maze/food logic that places food and the framebuffer writer.

---
 rtl/food_renderer.sv | 164 ++++++++++++++++
 tb/tb_food_renderer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_renderer.sv
// Food sprite blitter: walks the 8x8 layout of one food tile in row-major order
// and streams the visible pixels out with absolute screen coordinates.
module food_renderer #(
    parameter int TX_W             = 4,
    parameter int TY_W             = 4,
    parameter bit SKIP_TRANSPARENT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [TX_W-1:0] req_tile_x,
    input  logic [TY_W-1:0] req_tile_y,
    input  logic [1:0]      req_type,
    output logic [2:0]      lay_x,
    output logic [2:0]      lay_y,
    output logic [1:0]      lay_type,
    input  logic [1:0]      lay_value,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic [TX_W+2:0] pix_x,
    output logic [TY_W+2:0] pix_y,
    output logic [1:0]      pix_color,
    output logic            busy,
    output logic            done
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; a producer holds valid and its payload steady until that edge.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TX_W-1:0] tile_x_q;
    logic [TY_W-1:0] tile_y_q;

    logic accept;
    logic slot_free;
    logic skip_px;
    logic load;
    logic advance;
    logic last_px;
    logic drain_exit;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (advance && last_px) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_exit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        drain_exit = 1'b0;
        slot_free  = !pix_valid || pix_ready;
        skip_px    = SKIP_TRANSPARENT && (lay_value == 2'd0);
        last_px    = (lay_x == 3'd7) && (lay_y == 3'd7);
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
            end
            ST_SCAN: begin
                busy    = 1'b1;
                load    = !skip_px && slot_free;
                advance = skip_px || slot_free;
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                drain_exit = slot_free;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Request latch and scan counters; lay_x/lay_y are the counters themselves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_x_q <= '0;
            tile_y_q <= '0;
            lay_type <= 2'd0;
            lay_x    <= 3'd0;
            lay_y    <= 3'd0;
        end else if (accept) begin
            tile_x_q <= req_tile_x;
            tile_y_q <= req_tile_y;
            lay_type <= req_type;
            lay_x    <= 3'd0;
            lay_y    <= 3'd0;
        end else if (advance) begin
            if (last_px) begin
                lay_x <= 3'd0;
                lay_y <= 3'd0;
            end else begin
                lay_x <= lay_x + 3'd1;
                if (lay_x == 3'd7) begin
                    lay_y <= lay_y + 3'd1;
                end
            end
        end
    end

    // Single-entry output register; a load may replace a pixel leaving on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= 2'd0;
        end else if (load) begin
            pix_valid <= 1'b1;
            pix_x     <= {tile_x_q, lay_x};
            pix_y     <= {tile_y_q, lay_y};
            pix_color <= lay_value;
        end else if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= drain_exit;
        end
    end

endmodule

// File: tb/tb_food_renderer.sv
// Bench for food_renderer: two instances (all pixels / skip transparent) driven by a
// table of render jobs plus hand-written reset and request-hold sequences.
module tb_food_renderer;

    logic       clk;
    logic       reset;
    logic       req_valid  [2];
    logic       req_ready  [2];
    logic [3:0] req_tile_x [2];
    logic [3:0] req_tile_y [2];
    logic [1:0] req_type   [2];
    logic [2:0] lay_x      [2];
    logic [2:0] lay_y      [2];
    logic [1:0] lay_type   [2];
    logic [1:0] lay_value  [2];
    logic       pix_valid  [2];
    logic       pix_ready  [2];
    logic [6:0] pix_x      [2];
    logic [6:0] pix_y      [2];
    logic [1:0] pix_color  [2];
    logic       busy       [2];
    logic       done       [2];

    int checks;
    int errors;
    logic [15:0] exp_q[$];

    typedef struct {
        int         sel;
        logic [1:0] typ;
        logic [3:0] tx;
        logic [3:0] ty;
        int         mode;
        int         exp_count;
        int         exp_first;
        int         exp_done;
    } job_t;

    job_t jobs[8];

    food_renderer #(.TX_W(4), .TY_W(4), .SKIP_TRANSPARENT(1'b0)) dut_all (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_tile_x(req_tile_x[0]), .req_tile_y(req_tile_y[0]), .req_type(req_type[0]),
        .lay_x(lay_x[0]), .lay_y(lay_y[0]), .lay_type(lay_type[0]), .lay_value(lay_value[0]),
        .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]),
        .pix_x(pix_x[0]), .pix_y(pix_y[0]), .pix_color(pix_color[0]),
        .busy(busy[0]), .done(done[0])
    );

    food_renderer #(.TX_W(4), .TY_W(4), .SKIP_TRANSPARENT(1'b1)) dut_skip (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_tile_x(req_tile_x[1]), .req_tile_y(req_tile_y[1]), .req_type(req_type[1]),
        .lay_x(lay_x[1]), .lay_y(lay_y[1]), .lay_type(lay_type[1]), .lay_value(lay_value[1]),
        .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]),
        .pix_x(pix_x[1]), .pix_y(pix_y[1]), .pix_color(pix_color[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Layout ROM model: type 1 is a 2x4 pellet in columns 3..4 of rows 2..5
    function automatic logic [1:0] rom(input logic [1:0] t, input logic [2:0] x, input logic [2:0] y);
        logic [1:0] v;
        v = 2'd0;
        case (t)
            2'd1: begin
                if (y >= 3'd2 && y <= 3'd5 && (x == 3'd3 || x == 3'd4)) begin
                    v = (y == 3'd2 || y == 3'd5) ? 2'd1 : 2'd2;
                end
            end
            2'd2: v = x[1:0] + y[1:0];
            2'd3: v = 2'd3;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    always_comb begin
        lay_value[0] = rom(lay_type[0], lay_x[0], lay_y[0]);
        lay_value[1] = rom(lay_type[1], lay_x[1], lay_y[1]);
    end

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input int sel, input string tag);
        check_eq({tag, "_ctrl"}, {req_ready[sel], pix_valid[sel], busy[sel], done[sel]}, 4'b1000);
        check_eq({tag, "_pix"}, {pix_x[sel], pix_y[sel], pix_color[sel]}, 16'h0);
        check_eq({tag, "_lay"}, {lay_x[sel], lay_y[sel], lay_type[sel]}, 8'h0);
    endtask

    task automatic build_expected(input int sel, input logic [1:0] typ, input logic [3:0] tx, input logic [3:0] ty);
        logic [1:0] v;
        exp_q.delete();
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                v = rom(typ, 3'(x), 3'(y));
                if (sel == 0 || v != 2'd0) begin
                    exp_q.push_back({tx, 3'(x), ty, 3'(y), v});
                end
            end
        end
    endtask

    // Driver: present a request and take it on the next edge (E0)
    task automatic do_accept(input int sel, input logic [1:0] typ, input logic [3:0] tx, input logic [3:0] ty);
        @(negedge clk);
        req_valid[sel]  = 1'b1;
        req_tile_x[sel] = tx;
        req_tile_y[sel] = ty;
        req_type[sel]   = typ;
        check_eq("req_ready_idle", req_ready[sel], 1'b1);
        @(posedge clk);
        #1;
        check_eq("accept", {busy[sel], req_ready[sel], lay_x[sel], lay_y[sel], lay_type[sel]},
                 {1'b1, 1'b0, 3'd0, 3'd0, typ});
    endtask

    // Consume the render after E0; mode 0 ready=1, 1 random, 2 low for the first 10 edges
    task automatic run_render(input int sel, input logic [1:0] typ, input logic [3:0] tx, input logic [3:0] ty,
                              input int mode, input bit hold, input int exp_count,
                              input int exp_first, input int exp_done);
        int edge_n;
        int got;
        int first;
        bit seen_done;
        bit held;
        logic [15:0] held_pix;
        edge_n = 0; got = 0; first = 0; seen_done = 1'b0; held = 1'b0; held_pix = '0;
        build_expected(sel, typ, tx, ty);
        if (!hold) req_valid[sel] = 1'b0;
        while (!seen_done && edge_n < 400) begin
            @(negedge clk);
            if (hold) req_tile_x[sel] = 4'($urandom_range(0, 15));
            case (mode)
                0: pix_ready[sel] = 1'b1;
                1: pix_ready[sel] = 1'($urandom_range(0, 1));
                default: pix_ready[sel] = (edge_n + 1 > 10);
            endcase
            if (held) begin
                check_eq("hold_stable", {pix_valid[sel], pix_x[sel], pix_y[sel], pix_color[sel]}, {1'b1, held_pix});
            end
            if (pix_valid[sel] && pix_ready[sel]) begin
                if (exp_q.size() == 0) begin
                    check_eq("pixel_extra", got + 1, exp_count);
                end else begin
                    check_eq("pixel", {pix_x[sel], pix_y[sel], pix_color[sel]}, exp_q.pop_front());
                end
                got++;
            end
            held = pix_valid[sel] && !pix_ready[sel];
            held_pix = {pix_x[sel], pix_y[sel], pix_color[sel]};
            @(posedge clk);
            #1;
            edge_n++;
            if (pix_valid[sel] && first == 0) first = edge_n;
            if (done[sel]) begin
                seen_done = 1'b1;
                check_eq("done_state", {req_ready[sel], busy[sel], pix_valid[sel]}, 3'b100);
                if (exp_done > 0) check_eq("done_edge", edge_n, exp_done);
            end
        end
        check_eq("done_seen", seen_done, 1'b1);
        check_eq("pixel_count", got, exp_count);
        check_eq("pixels_left", exp_q.size(), 0);
        check_eq("first_pixel_edge", first, exp_first);
        if (!hold) begin
            @(posedge clk);
            #1;
            check_eq("done_pulse", done[sel], 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_tile_x[i] = 4'd0;
            req_tile_y[i] = 4'd0;
            req_type[i]   = 2'd0;
            pix_ready[i]  = 1'b1;
        end

        //          sel typ  tx     ty    mode cnt first done
        jobs[0] = '{0, 2'd1, 4'd2,  4'd3,  0, 64, 1,  65};
        jobs[1] = '{1, 2'd1, 4'd0,  4'd0,  0, 8,  20, 65};
        jobs[2] = '{1, 2'd0, 4'd7,  4'd4,  0, 0,  0,  65};
        jobs[3] = '{1, 2'd3, 4'd15, 4'd15, 0, 64, 1,  65};
        jobs[4] = '{1, 2'd2, 4'd1,  4'd6,  1, 48, 2,  -1};
        jobs[5] = '{0, 2'd3, 4'd4,  4'd9,  2, 64, 1,  74};
        jobs[6] = '{0, 2'd2, 4'd3,  4'd3,  1, 64, 1,  -1};
        jobs[7] = '{1, 2'd2, 4'd6,  4'd2,  0, 48, 2,  65};

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals(0, "rst_all");
        check_reset_vals(1, "rst_skip");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals(1, "idle_skip");

        for (int j = 0; j < 8; j++) begin
            do_accept(jobs[j].sel, jobs[j].typ, jobs[j].tx, jobs[j].ty);
            run_render(jobs[j].sel, jobs[j].typ, jobs[j].tx, jobs[j].ty, jobs[j].mode, 1'b0,
                       jobs[j].exp_count, jobs[j].exp_first, jobs[j].exp_done);
        end

        // req_valid held through a render while the tile column keeps changing
        do_accept(1, 2'd3, 4'd5, 4'd1);
        run_render(1, 2'd3, 4'd5, 4'd1, 0, 1'b1, 64, 1, 65);
        @(negedge clk);
        req_tile_x[1] = 4'd9;
        req_tile_y[1] = 4'd2;
        req_type[1]   = 2'd1;
        check_eq("rerequest_window", {done[1], req_ready[1]}, 2'b11);
        @(posedge clk);
        #1;
        check_eq("rerequest_accept", {busy[1], done[1], lay_type[1]}, {1'b1, 1'b0, 2'd1});
        run_render(1, 2'd1, 4'd9, 4'd2, 0, 1'b0, 8, 20, 65);

        // Reset while the 21st pixel is being scanned
        do_accept(0, 2'd3, 4'd6, 4'd6);
        req_valid[0] = 1'b0;
        pix_ready[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("pre_reset_pos", {pix_valid[0], lay_y[0], lay_x[0]}, {1'b1, 3'd2, 3'd4});
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals(0, "mid_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (5) begin
                @(posedge clk);
                #1;
                if (done[0]) saw_done = 1'b1;
            end
            check_eq("no_done_after_reset", saw_done, 1'b0);
        end
        do_accept(0, 2'd1, 4'd0, 4'd0);
        run_render(0, 2'd1, 4'd0, 4'd0, 0, 1'b0, 64, 1, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
